// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues fixed-latency instruction memory
// reads, captures the fetched word into the IR and applies PC-write requests.
module instr_fetch_unit #(
  parameter int              XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              MEM_LATENCY = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_req,
  input  logic            pc_write,
  input  logic [1:0]      pc_source,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] alu_out_reg,
  input  logic [XLEN-1:0] exc_target,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] imem_addr,
  output logic            imem_rd,
  output logic [31:0]     instruction_out,
  output logic            instr_valid,
  output logic            busy,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [2:0]      LAT  = 3'(MEM_LATENCY);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_t          state, state_next;
  logic [2:0]      cnt, cnt_next;
  logic [XLEN-1:0] fetch_addr, fetch_addr_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] sel;
  logic [31:0]     ir;
  logic            capture;
  logic            mis_next;
  logic            valid_q;
  logic            mis_q;

  // Fetch sequencing; the in-flight address is latched once and then left alone.
  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    fetch_addr_next = fetch_addr;
    imem_rd         = 1'b0;
    capture         = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_req && !reset) begin
          imem_rd         = 1'b1;
          fetch_addr_next = pc;
          cnt_next        = LAT;
          state_next      = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_next = cnt - 3'd1;
        if (cnt == 3'd1) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // PC update; reserved source and misaligned targets leave the PC untouched.
  always_comb begin
    pc_next  = pc;
    mis_next = 1'b0;
    case (pc_source)
      2'b00:   sel = alu_result;
      2'b01:   sel = alu_out_reg;
      2'b10:   sel = exc_target;
      default: sel = pc;
    endcase
    if (pc_write && (pc_source != 2'b11)) begin
      if (sel[1:0] != 2'b00) begin
        mis_next = 1'b1;
      end else begin
        pc_next = sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      fetch_addr <= RESET_PC;
      pc         <= RESET_PC;
      ir         <= 32'd0;
      valid_q    <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      fetch_addr <= fetch_addr_next;
      pc         <= pc_next;
      valid_q    <= capture;
      mis_q      <= mis_next;
      if (capture) begin
        ir <= imem_rdata;
      end
    end
  end

  assign busy            = (state == S_WAIT);
  assign imem_addr       = busy ? fetch_addr : pc;
  assign instruction_out = ir;
  assign instr_valid     = valid_q;
  assign misaligned      = mis_q;
  assign pc_out          = pc;
  assign pc_plus4        = pc + FOUR;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit, checked cycle by cycle against a
// transaction-level model that tracks fetches by absolute issue cycle.
module tb_instr_fetch_unit;

  localparam int          XLEN = 64;
  localparam int          LAT  = 3;
  localparam logic [63:0] RPC  = 64'h0000_0000_0000_1000;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        pc_write;
  logic [1:0]  pc_source;
  logic [63:0] alu_result;
  logic [63:0] alu_out_reg;
  logic [63:0] exc_target;
  logic [31:0] imem_rdata;
  logic [63:0] imem_addr;
  logic        imem_rd;
  logic [31:0] instruction_out;
  logic        instr_valid;
  logic        busy;
  logic [63:0] pc_out;
  logic [63:0] pc_plus4;
  logic        misaligned;

  instr_fetch_unit #(
    .XLEN(XLEN),
    .RESET_PC(RPC),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fetch_req(fetch_req),
    .pc_write(pc_write),
    .pc_source(pc_source),
    .alu_result(alu_result),
    .alu_out_reg(alu_out_reg),
    .exc_target(exc_target),
    .imem_rdata(imem_rdata),
    .imem_addr(imem_addr),
    .imem_rd(imem_rd),
    .instruction_out(instruction_out),
    .instr_valid(instr_valid),
    .busy(busy),
    .pc_out(pc_out),
    .pc_plus4(pc_plus4),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: a fetch is outstanding from issue cycle until issue+LAT.
  logic [63:0] m_pc;
  logic [63:0] m_faddr;
  logic [31:0] m_ir;
  bit          m_out;
  bit          m_valid;
  bit          m_mis;
  int          m_issue;
  int          cyc;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [63:0] randTarget();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0:       return v;
      1:       return 64'hFFFF_FFFF_FFFF_FFFC;
      2:       return {56'd0, v[7:0]};
      default: return v & ~64'h3;
    endcase
  endfunction

  task automatic applyStimulus(input bit allow_reset);
    reset       = allow_reset && ($urandom_range(0, 39) == 0);
    fetch_req   = ($urandom_range(0, 1) == 1);
    pc_write    = ($urandom_range(0, 3) == 0);
    pc_source   = 2'($urandom_range(0, 3));
    alu_result  = randTarget();
    alu_out_reg = randTarget();
    exc_target  = randTarget();
    imem_rdata  = $urandom();
  endtask

  task automatic checkAll();
    logic [63:0] exp_addr;
    exp_addr = m_out ? m_faddr : m_pc;
    checkOutput("imem_rd", {63'd0, imem_rd}, {63'd0, (!reset && !m_out && fetch_req)});
    checkOutput("imem_addr", imem_addr, exp_addr);
    checkOutput("busy", {63'd0, busy}, {63'd0, m_out});
    checkOutput("instr_valid", {63'd0, instr_valid}, {63'd0, m_valid});
    checkOutput("instruction_out", {32'd0, instruction_out}, {32'd0, m_ir});
    checkOutput("pc_out", pc_out, m_pc);
    checkOutput("pc_plus4", pc_plus4, m_pc + 64'd4);
    checkOutput("misaligned", {63'd0, misaligned}, {63'd0, m_mis});
  endtask

  task automatic modelReset();
    m_pc    = RPC;
    m_faddr = RPC;
    m_ir    = 32'd0;
    m_out   = 1'b0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    m_issue = 0;
  endtask

  task automatic modelStep();
    bit          was_out;
    logic [63:0] sel;
    if (reset) begin
      modelReset();
    end else begin
      was_out = m_out;
      m_valid = was_out && (cyc == m_issue + LAT);
      if (m_valid) begin
        m_ir  = imem_rdata;
        m_out = 1'b0;
      end else if (!was_out && fetch_req) begin
        m_out   = 1'b1;
        m_issue = cyc;
        m_faddr = m_pc;
      end
      m_mis = 1'b0;
      if (pc_write && pc_source != 2'b11) begin
        sel = (pc_source == 2'b00) ? alu_result :
              (pc_source == 2'b01) ? alu_out_reg : exc_target;
        if (sel[1:0] != 2'b00) m_mis = 1'b1;
        else                   m_pc  = sel;
      end
    end
    cyc++;
  endtask

  initial begin
    cyc         = 0;
    reset       = 1'b1;
    fetch_req   = 1'b0;
    pc_write    = 1'b0;
    pc_source   = 2'b00;
    alu_result  = '0;
    alu_out_reg = '0;
    exc_target  = '0;
    imem_rdata  = '0;
    repeat (2) @(posedge clk);
    modelReset();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      applyStimulus(i > 4);
      #1;
      checkAll();
      @(posedge clk);
      modelStep();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
